// File: rtl/apb_i2c_regbank_if.sv
// APB slave-side signal bundle for the I2C register bank.
// The master modport drives the request fields; the slave modport answers with ready/data/error.
interface apb_i2c_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_i2c_regbank.sv
// APB register bank for the I2C master: config regs, TX/RX FIFOs, sticky status, registered irq.
// Latency: pready after WAIT_STATES extra access cycles; backpressure via pready, full/empty FIFO accesses get pslverr.
module apb_i2c_regbank #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              apb_clk,
  input  logic              preset,
  apb_i2c_regbank_if.slave  bus,
  output logic              cfg_en,
  output logic              cfg_rw,
  output logic              cfg_start,
  output logic [6:0]        cfg_slave_addr,
  output logic [DATA_W-1:0] cfg_prescale,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_empty,
  input  logic              tx_pop,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_push,
  input  logic              core_busy,
  input  logic              core_nack,
  output logic              irq
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  WS       = 3'(WAIT_STATES);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [2:0]        wcnt;
  logic              abort;
  logic              access, commit, err, wr_commit, rd_commit;
  logic [2:0]        reg_sel;
  logic [DATA_W-1:0] rdata;
  logic              cfg_irq_en, sts_nack, sts_rx_ovf;
  logic              sts_w1c;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [AW:0]       tx_cnt, rx_cnt;
  logic              tx_full, rx_empty, rx_full;
  logic              tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok, flush;

  // An access interrupted by reset stays dead until penable drops.
  assign access      = bus.psel & bus.penable & ~abort & ~preset;
  assign bus.pready  = access & (wcnt == WS);
  assign commit      = bus.pready;
  assign reg_sel     = bus.paddr[2:0];

  always_comb begin
    err = 1'b0;
    if (bus.paddr[ADDR_W-1:3] != '0) begin
      err = 1'b1;
    end else begin
      case (reg_sel)
        3'd4:       err = bus.pwrite & tx_full;
        3'd5:       err = ~bus.pwrite & rx_empty;
        3'd6, 3'd7: err = 1'b1;
        default:    err = 1'b0;
      endcase
    end
  end

  assign wr_commit = commit & bus.pwrite & ~err;
  assign rd_commit = commit & ~bus.pwrite & ~err;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0: rdata[3:0] = {cfg_irq_en, 1'b0, cfg_rw, cfg_en};
      3'd1: rdata[6:0] = {sts_rx_ovf, sts_nack, rx_full, rx_empty, tx_full, tx_empty, core_busy};
      3'd2: rdata[6:0] = cfg_slave_addr;
      3'd3: rdata      = cfg_prescale;
      3'd5: rdata      = rx_mem[rx_rptr];
      default: rdata   = '0;
    endcase
  end

  assign bus.prdata  = rd_commit ? rdata : '0;
  assign bus.pslverr = commit & err;

  assign tx_empty   = (tx_cnt == '0);
  assign tx_full    = (tx_cnt == FULL_CNT);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == FULL_CNT);
  assign tx_data    = tx_empty ? '0 : tx_mem[tx_rptr];
  assign tx_push_ok = wr_commit & (reg_sel == 3'd4);
  assign tx_pop_ok  = tx_pop & ~tx_empty;
  assign rx_push_ok = rx_push & ~rx_full;
  assign rx_pop_ok  = rd_commit & (reg_sel == 3'd5);
  assign flush      = wr_commit & (reg_sel == 3'd0) & cfg_en & ~bus.pwdata[0];
  assign sts_w1c    = wr_commit & (reg_sel == 3'd1);

  always_ff @(posedge apb_clk) begin
    if (preset) begin
      wcnt  <= 3'd0;
      abort <= bus.psel & bus.penable;
    end else begin
      abort <= abort & bus.penable;
      wcnt  <= (access & ~bus.pready) ? wcnt + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge apb_clk) begin
    if (preset) begin
      cfg_en         <= 1'b0;
      cfg_rw         <= 1'b0;
      cfg_irq_en     <= 1'b0;
      cfg_start      <= 1'b0;
      cfg_slave_addr <= '0;
      cfg_prescale   <= '0;
      sts_nack       <= 1'b0;
      sts_rx_ovf     <= 1'b0;
      irq            <= 1'b0;
    end else begin
      cfg_start <= wr_commit & (reg_sel == 3'd0) & bus.pwdata[0] & bus.pwdata[2] & ~core_busy;
      if (wr_commit && reg_sel == 3'd0) begin
        cfg_en     <= bus.pwdata[0];
        cfg_rw     <= bus.pwdata[1];
        cfg_irq_en <= bus.pwdata[3];
      end
      if (wr_commit && reg_sel == 3'd2) cfg_slave_addr <= bus.pwdata[6:0];
      if (wr_commit && reg_sel == 3'd3) cfg_prescale   <= bus.pwdata;
      // Set terms are OR-ed last so a same-cycle event beats the W1C.
      sts_nack   <= core_nack | (sts_nack & ~(sts_w1c & bus.pwdata[5]));
      sts_rx_ovf <= (rx_push & rx_full) | (sts_rx_ovf & ~(sts_w1c & bus.pwdata[6]));
      irq        <= cfg_irq_en & (sts_nack | sts_rx_ovf | ~rx_empty);
    end
  end

  always_ff @(posedge apb_clk) begin
    if (tx_push_ok) tx_mem[tx_wptr] <= bus.pwdata;
    if (rx_push_ok) rx_mem[rx_wptr] <= rx_data;
  end

  always_ff @(posedge apb_clk) begin
    if (preset || flush) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (tx_push_ok) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop_ok)  tx_rptr <= tx_rptr + AW'(1);
      if (rx_push_ok) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop_ok)  rx_rptr <= rx_rptr + AW'(1);
      tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push_ok} - {{AW{1'b0}}, tx_pop_ok};
      rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_push_ok} - {{AW{1'b0}}, rx_pop_ok};
    end
  end
endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Bench for apb_i2c_regbank (WAIT_STATES=2, depth 8): vector table, corner sequences, random ops vs queue model.
module tb_apb_i2c_regbank;
  logic       clk = 1'b0;
  logic       preset;
  logic       cfg_en, cfg_rw, cfg_start, tx_empty, irq;
  logic [6:0] cfg_slave_addr;
  logic [7:0] cfg_prescale, tx_data, rx_data;
  logic       tx_pop, rx_push, core_busy, core_nack;

  int n_vec = 0;
  int n_bad = 0;

  apb_i2c_regbank_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_i2c_regbank #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(8), .WAIT_STATES(2)) dut (
    .apb_clk(clk), .preset(preset), .bus(bus),
    .cfg_en(cfg_en), .cfg_rw(cfg_rw), .cfg_start(cfg_start),
    .cfg_slave_addr(cfg_slave_addr), .cfg_prescale(cfg_prescale),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_pop(tx_pop),
    .rx_data(rx_data), .rx_push(rx_push),
    .core_busy(core_busy), .core_nack(core_nack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  // Behavioural model: register values plus FIFO contents as queues.
  logic       m_en, m_rw, m_irqen, m_nack, m_ovf;
  logic [6:0] m_sa;
  logic [7:0] m_ps;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_rw = 0; m_irqen = 0; m_nack = 0; m_ovf = 0; m_sa = '0; m_ps = '0;
    txq.delete();
    rxq.delete();
  endtask

  task automatic do_reset();
    preset = 1'b1;
    repeat (3) @(negedge clk);
    preset = 1'b0;
    model_reset();
  endtask

  // Starts at a negedge; engine inputs are applied only in the commit cycle. Ends at a negedge, bus idle.
  task automatic apb_sim(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic pop, input logic push, input logic [7:0] rxd, input logic nk,
                         output logic [7:0] rd, output logic er, output int waits, output logic st);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
    rd = '0; er = 1'b0; waits = 0;
    @(negedge clk);
    bus.penable = 1'b1;
    forever begin
      #1;
      waits++;
      if (bus.pready === 1'b1) begin
        rd = bus.prdata; er = bus.pslverr;
        tx_pop = pop; rx_push = push; rx_data = rxd; core_nack = nk;
        break;
      end
      if (waits >= 16) begin
        n_vec++; n_bad++;
        $display("FAIL apb_timeout: pready not seen after %0d access cycles, required within 3", waits);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    st = cfg_start;
    tx_pop = 0; rx_push = 0; core_nack = 0;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     output logic [7:0] rd, output logic er);
    int w;
    logic st;
    apb_sim(wr, addr, wdata, 1'b0, 1'b0, 8'h00, 1'b0, rd, er, w, st);
  endtask

  task automatic eng(input logic pop, input logic push, input logic [7:0] d, input logic nk);
    tx_pop = pop; rx_push = push; rx_data = d; core_nack = nk;
    @(negedge clk);
    tx_pop = 0; rx_push = 0; core_nack = 0;
  endtask

  // Expected response of one APB commit (with same-cycle engine events), then state advance.
  task automatic model_apb(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                           input logic pop, input logic push, input logic [7:0] rxd, input logic nk,
                           output logic [7:0] erd, output logic eer, output logic est);
    int tsz = txq.size();
    int rsz = rxq.size();
    logic [2:0] a = addr[2:0];
    logic ok;
    eer = (addr[7:3] != 0) || (a >= 6) || (wr && a == 4 && tsz == 8) || (!wr && a == 5 && rsz == 0);
    ok  = !eer;
    erd = 8'h00;
    if (!wr && ok) begin
      case (a)
        3'd0: erd = {4'b0, m_irqen, 1'b0, m_rw, m_en};
        3'd1: erd = {1'b0, m_ovf, m_nack, rsz == 8, rsz == 0, tsz == 8, tsz == 0, core_busy};
        3'd2: erd = {1'b0, m_sa};
        3'd3: erd = m_ps;
        3'd5: erd = rxq[0];
        default: erd = 8'h00;
      endcase
    end
    est = wr && ok && a == 0 && wd[0] && wd[2] && !core_busy;
    if (pop && tsz > 0) void'(txq.pop_front());
    if (wr && ok && a == 4) txq.push_back(wd);
    if (!wr && ok && a == 5) void'(rxq.pop_front());
    if (wr && ok && a == 1) begin
      if (wd[5]) m_nack = 0;
      if (wd[6]) m_ovf = 0;
    end
    if (nk) m_nack = 1;
    if (push) begin
      if (rsz == 8) m_ovf = 1;
      else rxq.push_back(rxd);
    end
    if (wr && ok && a == 2) m_sa = wd[6:0];
    if (wr && ok && a == 3) m_ps = wd;
    if (wr && ok && a == 0) begin
      if (m_en && !wd[0]) begin
        txq.delete();
        rxq.delete();
      end
      m_en = wd[0]; m_rw = wd[1]; m_irqen = wd[3];
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("irq", 32'(irq), 32'(m_irqen & (m_nack | m_ovf | (rxq.size() > 0))));
    chk("tx_empty", 32'(tx_empty), 32'(txq.size() == 0));
    chk("tx_data", 32'(tx_data), (txq.size() > 0) ? 32'(txq[0]) : 32'h0);
    chk("cfg_ctrl", 32'({cfg_en, cfg_rw, cfg_start}), 32'({m_en, m_rw, 1'b0}));
    chk("cfg_addr_ps", 32'({cfg_slave_addr, cfg_prescale}), 32'({m_sa, m_ps}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[16];
    logic [7:0] rd, erd;
    logic       er, eer, st, est;
    int         w;

    tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'h0A, 1'b0};
    tbl[2]  = '{1'b1, 8'h03, 8'h3C, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h03, 8'h00, 8'h3C, 1'b0};
    tbl[4]  = '{1'b1, 8'h02, 8'hFF, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h02, 8'h00, 8'h7F, 1'b0};
    tbl[6]  = '{1'b0, 8'h04, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 8'h06, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 8'h07, 8'h12, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 8'h11, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 8'h05, 8'h55, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 8'h00, 8'h09, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 8'h00, 8'h09, 1'b0};
    tbl[14] = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 8'h01, 8'h00, 8'h0A, 1'b0};

    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
    tx_pop = 0; rx_push = 0; rx_data = '0; core_busy = 0; core_nack = 0;
    do_reset();
    #1;
    chk("rst_apb", 32'({bus.pready, bus.pslverr, bus.prdata}), 32'h0);
    chk("rst_tx", 32'({tx_empty, tx_data}), 32'h100);
    chk("rst_cfg", 32'({cfg_en, cfg_rw, cfg_start, cfg_slave_addr, cfg_prescale}), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      apb_sim(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, 1'b0, 8'h00, 1'b0, rd, er, w, st);
      chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_pslverr", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_access_cycles", i), 32'(w), 32'd3);
    end

    // TX fill to full, rejected 9th push, in-order drain.
    for (int i = 0; i < 8; i++) begin
      apb(1'b1, 8'h04, 8'(8'h10 + i), rd, er);
      chk("tx_push_err", 32'(er), 32'h0);
    end
    apb(1'b0, 8'h01, 8'h00, rd, er);
    chk("tx_full_status", 32'(rd), 32'h0C);
    apb(1'b1, 8'h04, 8'h99, rd, er);
    chk("tx_overfill_err", 32'(er), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("tx_drain_data", 32'(tx_data), 32'(8'h10 + i));
      eng(1'b1, 1'b0, 8'h00, 1'b0);
    end
    chk("tx_drain_empty", 32'(tx_empty), 32'h1);

    // RX empty read error, then one byte through.
    apb(1'b0, 8'h05, 8'h00, rd, er);
    chk("rx_empty_rd", 32'({er, rd}), 32'h100);
    eng(1'b0, 1'b1, 8'hA5, 1'b0);
    apb(1'b0, 8'h05, 8'h00, rd, er);
    chk("rx_rd", 32'({er, rd}), 32'h0A5);
    apb(1'b0, 8'h01, 8'h00, rd, er);
    chk("rx_status", 32'(rd), 32'h0A);

    // START pulse gating on core_busy.
    apb_sim(1'b1, 8'h00, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, rd, er, w, st);
    chk("start_pulse", 32'(st), 32'h1);
    @(negedge clk);
    chk("start_single", 32'(cfg_start), 32'h0);
    apb(1'b0, 8'h00, 8'h00, rd, er);
    chk("ctrl_start_reads0", 32'(rd), 32'h03);
    core_busy = 1'b1;
    apb_sim(1'b1, 8'h00, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, rd, er, w, st);
    chk("start_busy_blocked", 32'(st), 32'h0);
    core_busy = 1'b0;

    // NACK sticky bit, irq latency, W1C.
    apb(1'b1, 8'h00, 8'h09, rd, er);
    eng(1'b0, 1'b0, 8'h00, 1'b1);
    chk("irq_lat0", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_nack", 32'(irq), 32'h1);
    apb(1'b0, 8'h01, 8'h00, rd, er);
    chk("nack_status", 32'(rd), 32'h2A);
    apb(1'b1, 8'h01, 8'h20, rd, er);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);
    apb(1'b0, 8'h01, 8'h00, rd, er);
    chk("nack_w1c_status", 32'(rd), 32'h0A);

    // Reset in the middle of an access.
    for (int i = 0; i < 3; i++) apb(1'b1, 8'h04, 8'(8'h30 + i), rd, er);
    bus.psel = 1; bus.pwrite = 1; bus.paddr = 8'h00; bus.pwdata = 8'h01; bus.penable = 0;
    @(negedge clk);
    bus.penable = 1;
    #1 chk("abort_pre", 32'(bus.pready), 32'h0);
    preset = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("abort_in_reset", 32'(bus.pready), 32'h0);
    preset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("abort_after_reset", 32'(bus.pready), 32'h0);
    end
    @(negedge clk);
    bus.psel = 0; bus.penable = 0;
    chk("abort_tx_empty", 32'({tx_empty, cfg_en, irq}), 32'h4);
    model_reset();
    apb(1'b0, 8'h00, 8'h00, rd, er);
    chk("abort_ctrl", 32'({er, rd}), 32'h000);

    // Random operations against the queue model.
    for (int k = 0; k < 400; k++) begin
      core_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        logic p  = ($urandom_range(0, 1) == 0);
        logic q  = ($urandom_range(0, 1) == 0);
        logic n  = ($urandom_range(0, 7) == 0);
        logic [7:0] d = 8'($urandom);
        chk("rnd_tx_head", 32'(tx_data), (txq.size() > 0) ? 32'(txq[0]) : 32'h0);
        eng(p, q, d, n);
        if (p && txq.size() > 0) void'(txq.pop_front());
        if (n) m_nack = 1;
        if (q) begin
          if (rxq.size() == 8) m_ovf = 1;
          else rxq.push_back(d);
        end
      end else begin
        int s = $urandom_range(0, 19);
        logic wr = 1'($urandom_range(0, 1));
        logic [7:0] a;
        logic [7:0] wd = 8'($urandom);
        logic p  = ($urandom_range(0, 2) == 0);
        logic q  = ($urandom_range(0, 2) == 0);
        logic n  = ($urandom_range(0, 5) == 0);
        logic [7:0] d = 8'($urandom);
        if (s < 5)        begin a = 8'h04; wr = 1'b1; end
        else if (s < 8)   begin a = 8'h05; wr = 1'b0; end
        else if (s < 10)  a = 8'h01;
        else if (s == 10) begin a = 8'h00; wr = 1'b1; wd[0] = ($urandom_range(0, 3) != 0); end
        else if (s < 13)  a = 8'($urandom_range(2, 3));
        else if (s == 13) a = 8'($urandom_range(6, 7));
        else if (s == 14) a = 8'($urandom_range(8, 255));
        else              begin a = 8'($urandom_range(0, 5)); wr = 1'b0; end
        model_apb(wr, a, wd, p, q, d, n, erd, eer, est);
        apb_sim(wr, a, wd, p, q, d, n, rd, er, w, st);
        chk($sformatf("rnd_rdata a=%0h w=%0d", a, wr), 32'(rd), 32'(erd));
        chk($sformatf("rnd_pslverr a=%0h w=%0d", a, wr), 32'(er), 32'(eer));
        chk("rnd_start", 32'(st), 32'(est));
      end
      idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
